bit_count_engine: RTL and testbench

- Parametrised successor to the single-bit-clear population-count datapath.
- Controller and datapath in one block, with a go/done handshake, a selectable count mode (ones or zeros), and a configurable number of lowest-set-bit clears per cycle.
- Sits as a leaf compute unit behind a host register interface or a test wrapper.
- Result latency scales with ceil(popcount/CLEARS).

---
 rtl/bit_count_engine_if.sv | 34 +++
 rtl/bit_count_engine.sv | 110 +++++++++++
 tb/tb_bit_count_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bit_count_engine_if.sv
// Operand/result handshake bundle for bit_count_engine; cycles port exists only
// when BIT_COUNT_CYCLES_EN is defined.
interface bit_count_engine_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(WIDTH + 2);

    logic             go;
    logic [WIDTH-1:0] in;
    logic             count_zeros;
    logic             busy;
    logic             done;
    logic [CW-1:0]    out;
`ifdef BIT_COUNT_CYCLES_EN
    logic [YW-1:0]    cycles;
`endif

    modport master (
`ifdef BIT_COUNT_CYCLES_EN
        input  cycles,
`endif
        output go, in, count_zeros,
        input  busy, done, out
    );

    modport slave (
`ifdef BIT_COUNT_CYCLES_EN
        output cycles,
`endif
        input  go, in, count_zeros,
        output busy, done, out
    );
endinterface

// File: rtl/bit_count_engine.sv
// Population counter (ones or zeros) clearing CLEARS lowest set bits per cycle.
// Latency: ceil(popcount/CLEARS)+1 edges from go to done; go ignored while busy.
// Optional BIT_COUNT_CYCLES_EN adds a cycles result reporting that latency.
module bit_count_engine #(
    parameter int WIDTH  = 32,
    parameter int CLEARS = 1
) (
    input  logic              clk,
    input  logic              rst,
    bit_count_engine_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(WIDTH + 2);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    ONE_C = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] n_nxt;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    out_r;
    logic [CW-1:0]    inc;
    logic             accept;
    logic             finish;

    assign accept = bus.go && (state == S_IDLE || state == S_DONE);
    assign finish = (state == S_COMPUTE) && (n_r == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.go) state_nxt = S_COMPUTE;
            S_COMPUTE: if (n_r == '0) state_nxt = S_DONE;
            S_DONE:    if (bus.go) state_nxt = S_COMPUTE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == S_COMPUTE);
        bus.done = (state == S_DONE);
    end

    // Stages whose input is already zero pass it through and add nothing.
    always_comb begin
        n_nxt = n_r;
        inc   = '0;
        for (int i = 0; i < CLEARS; i++) begin
            if (n_nxt != '0) begin
                n_nxt = n_nxt & (n_nxt - ONE_W);
                inc   = inc + ONE_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            n_r     <= '0;
            count_r <= '0;
            out_r   <= '0;
        end else if (accept) begin
            n_r     <= bus.count_zeros ? ~bus.in : bus.in;
            count_r <= '0;
        end else if (state == S_COMPUTE) begin
            if (n_r == '0) begin
                out_r <= count_r;
            end else begin
                n_r     <= n_nxt;
                count_r <= count_r + inc;
            end
        end
    end

    assign bus.out = out_r;

`ifdef BIT_COUNT_CYCLES_EN
    logic [YW-1:0] cyc_cnt;
    logic [YW-1:0] cycles_r;
    localparam logic [YW-1:0] ONE_Y = {{(YW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_cnt  <= '0;
            cycles_r <= '0;
        end else if (accept) begin
            cyc_cnt <= '0;
        end else if (state == S_COMPUTE) begin
            cyc_cnt <= cyc_cnt + ONE_Y;
            if (finish) cycles_r <= cyc_cnt + ONE_Y;
        end
    end

    assign bus.cycles = cycles_r;
`endif
endmodule

// File: tb/tb_bit_count_engine.sv
// Directed bench for bit_count_engine (WIDTH=8, CLEARS=1 and CLEARS=3) with a latency/popcount reference model.
module tb_bit_count_engine;
    logic       clk;
    logic       rst;
    logic       go_s [2];
    logic [7:0] in_s [2];
    logic       cz_s [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic [3:0] out_o [2];
`ifdef BIT_COUNT_CYCLES_EN
    logic [3:0] cyc_o [2];
`endif

    int vectors = 0;
    int miscompares = 0;

    bit_count_engine_if #(.WIDTH(8)) bus1 ();
    bit_count_engine_if #(.WIDTH(8)) bus3 ();

    bit_count_engine #(.WIDTH(8), .CLEARS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    bit_count_engine #(.WIDTH(8), .CLEARS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus1.go = go_s[0];
    assign bus1.in = in_s[0];
    assign bus1.count_zeros = cz_s[0];
    assign bus3.go = go_s[1];
    assign bus3.in = in_s[1];
    assign bus3.count_zeros = cz_s[1];
    assign busy_o[0] = bus1.busy;
    assign done_o[0] = bus1.done;
    assign out_o[0]  = bus1.out;
    assign busy_o[1] = bus3.busy;
    assign done_o[1] = bus3.done;
    assign out_o[1]  = bus3.out;
`ifdef BIT_COUNT_CYCLES_EN
    assign cyc_o[0] = bus1.cycles;
    assign cyc_o[1] = bus3.cycles;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: an accepted op finishes ceil(p/C)+1 edges later with count p.
    bit         armed = 1'b0;
    bit         m_busy [2];
    bit         m_done [2];
    int         m_out  [2];
    int         m_left [2];
    int         m_pend [2];
    int         m_lat  [2];
    int         m_cyc  [2];

    always @(posedge clk) begin
        armed <= 1'b1;
        for (int d = 0; d < 2; d++) begin
            int p;
            int c;
            int lat;
            c = (d == 0) ? 1 : 3;
            if (!rst) begin
                m_busy[d] <= 1'b0;
                m_done[d] <= 1'b0;
                m_out[d]  <= 0;
                m_left[d] <= 0;
                m_cyc[d]  <= 0;
            end else if (!m_busy[d]) begin
                if (go_s[d]) begin
                    p   = $countones(cz_s[d] ? ~in_s[d] : in_s[d]);
                    lat = (p + c - 1) / c + 1;
                    m_busy[d] <= 1'b1;
                    m_done[d] <= 1'b0;
                    m_left[d] <= lat;
                    m_lat[d]  <= lat;
                    m_pend[d] <= p;
                end
            end else begin
                if (m_left[d] == 1) begin
                    m_busy[d] <= 1'b0;
                    m_done[d] <= 1'b1;
                    m_out[d]  <= m_pend[d];
                    m_cyc[d]  <= m_lat[d];
                end
                m_left[d] <= m_left[d] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d_busy", d), {31'd0, busy_o[d]}, {31'd0, m_busy[d]});
                check($sformatf("dut%0d_done", d), {31'd0, done_o[d]}, {31'd0, m_done[d]});
                check($sformatf("dut%0d_out", d), {28'd0, out_o[d]}, m_out[d]);
`ifdef BIT_COUNT_CYCLES_EN
                check($sformatf("dut%0d_cycles", d), {28'd0, cyc_o[d]}, m_cyc[d]);
`endif
            end
        end
    end

    task automatic start(input int d, input logic [7:0] v, input logic cz);
        go_s[d] = 1'b1;
        in_s[d] = v;
        cz_s[d] = cz;
        @(posedge clk);
        #1;
        go_s[d] = 1'b0;
        in_s[d] = ~v;
        cz_s[d] = ~cz;
    endtask

    task automatic wait_done(input int d, input int from, output int edges);
        edges = from;
        while (edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (done_o[d]) break;
        end
    endtask

    initial begin
        int e;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            go_s[d] = 1'b0;
            in_s[d] = 8'h00;
            cz_s[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy_o[0]}, 0);
        check("reset_done", {31'd0, done_o[0]}, 0);
        check("reset_out", {28'd0, out_o[0]}, 0);
        rst = 1'b1;

        start(0, 8'b1011_0010, 1'b0);
        check("b2_busy_on_accept", {31'd0, busy_o[0]}, 1);
        wait_done(0, 0, e);
        check("b2_latency", e, 5);
        check("b2_out", {28'd0, out_o[0]}, 4);
`ifdef BIT_COUNT_CYCLES_EN
        check("b2_cycles", {28'd0, cyc_o[0]}, 5);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("b2_out_held", {28'd0, out_o[0]}, 4);
        check("b2_done_held", {31'd0, done_o[0]}, 1);

        start(0, 8'h00, 1'b0);
        wait_done(0, 0, e);
        check("zero_latency", e, 1);
        check("zero_out", {28'd0, out_o[0]}, 0);

        start(0, 8'hFF, 1'b0);
        check("ff_done_falls", {31'd0, done_o[0]}, 0);
        wait_done(0, 0, e);
        check("ff_latency", e, 9);
        check("ff_out", {28'd0, out_o[0]}, 8);

        start(1, 8'hFF, 1'b0);
        wait_done(1, 0, e);
        check("c3_ff_latency", e, 4);
        check("c3_ff_out", {28'd0, out_o[1]}, 8);
        start(1, 8'h81, 1'b0);
        wait_done(1, 0, e);
        check("c3_81_latency", e, 2);
        check("c3_81_out", {28'd0, out_o[1]}, 2);

        start(0, 8'b1111_0100, 1'b1);
        wait_done(0, 0, e);
        check("zeros_latency", e, 4);
        check("zeros_out", {28'd0, out_o[0]}, 3);
        start(0, 8'b1111_0100, 1'b0);
        wait_done(0, 0, e);
        check("ones_latency", e, 6);
        check("ones_out", {28'd0, out_o[0]}, 5);

        start(0, 8'h0F, 1'b0);
        @(posedge clk);
        #1;
        go_s[0] = 1'b1;
        in_s[0] = 8'h01;
        @(posedge clk);
        #1;
        go_s[0] = 1'b0;
        wait_done(0, 2, e);
        check("ignore_latency", e, 5);
        check("ignore_out", {28'd0, out_o[0]}, 4);

        start(0, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", {31'd0, busy_o[0]}, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_busy", {31'd0, busy_o[0]}, 0);
        check("abort_done", {31'd0, done_o[0]}, 0);
        check("abort_out", {28'd0, out_o[0]}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", {31'd0, done_o[0]}, 0);

        start(0, 8'h03, 1'b0);
        wait_done(0, 0, e);
        check("post_abort_latency", e, 3);
        check("post_abort_out", {28'd0, out_o[0]}, 2);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
